pe_sequencer: RTL and testbench
===============================

# pe_sequencer

Issue-side controller for one `processing_element` lane. It accepts a vector operation (opcode, length, ReLU flag) over a valid/ready handshake. It consumes operand beats from the operand-fetch stream and drives every PE mux/enable control cycle by cycle. It presents PE results to the writeback stage over a second valid/ready handshake. The PE itself is the responder; this block is the only driver of its control pins.

## Interface
Parameters:
- `LEN_W`, default 8: width of the operation length (number of operand beats).

Ports:
- `clk`, in, 1: clock.
- `n_reset`, in, 1: reset, asynchronous, active-low.
- `op_valid`, in, 1: operation offered.
- `op_ready`, out, 1: operation accepted when high together with `op_valid`.
- `op_code`, in, 2: operation; 0 ADD, 1 MUL, 2 MAC, 3 RELU.
- `op_len`, in, `LEN_W`: number of operand beats.
- `op_relu`, in, 1: apply ReLU to results of ADD/MUL/MAC.
- `in_valid`, in, 1: operand beat (a, b) present at the PE inputs.
- `in_ready`, out, 1: operand beat consumed this cycle.
- `wb_valid`, out, 1: PE output `r` holds a result.
- `wb_ready`, in, 1: writeback accepts `r`.
- `wb_last`, out, 1: current writeback is the last one of the operation.
- `mux_add_a`, out, 2: PE control.
- `mux_add_b`, out, 2: PE control.
- `mux_c_acc`, out, 1: PE control.
- `mux_sat8`, out, 2: PE control.
- `mux_relu`, out, 1: PE control.
- `mux_res`, out, 2: PE control.
- `mux_comb`, out, 1: PE control.
- `enable_acc`, out, 1: PE control.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle pulse after an operation completes.

## Operation
- Registers: `state` (IDLE, RUN, FINAL), `beats_left` (`LEN_W`), `op_q`, `relu_q`, `first_q`, `done`.
- `op_ready = (state==IDLE)`. On accept:
  - `op_len!=0`: latch op, `beats_left=op_len`, `first_q=1`, go to RUN.
  - `op_len==0`: stay IDLE, pulse `done` next cycle, no beats and no writeback.
- A beat is a handshake `hs = in_valid & in_ready`.
- On each `hs`: decrement `beats_left` and clear `first_q`. On the last `hs`:
  - ADD/MUL/RELU go to IDLE and pulse `done`.
  - MAC goes to FINAL.
- Elementwise ops (ADD/MUL/RELU) in RUN:
  - `in_ready = wb_ready`, `wb_valid = in_valid`.
  - `wb_last = (beats_left==1)`.
  - `enable_acc=0`, `mux_comb=1`.
- ADD controls: `mux_add_a=0`, `mux_add_b=0`, `mux_sat8=2`.
- MUL controls: `mux_sat8=1`.
- ADD and MUL result select: `mux_res` is 2, or 3 with `mux_relu=1` when `relu_q`.
- RELU controls: `mux_relu=0`, `mux_res=3`.
- MAC in RUN:
  - `in_ready=1`, `wb_valid=0`, `enable_acc=hs`.
  - First beat (`first_q`): `mux_res=0`, loading the truncated product.
  - Later beats: `mux_add_a=1`, `mux_add_b=1`, `mux_c_acc=1`, `mux_res=1` (saturated 12-bit accumulate).
- MAC in FINAL:
  - `wb_valid=1`, `wb_last=1`, `enable_acc=0`, `in_ready=0`.
  - `mux_c_acc=1`, `mux_sat8=0`, `mux_comb=1`.
  - `mux_res` is 2, or 3 with `mux_relu=1` when `relu_q`.
  - `r` is the accumulator saturated to int8.
  - Leave on `wb_ready`: go to IDLE and pulse `done`.
- Defaults: any control not named above is 0. All controls are 0 in IDLE.
- `op_valid` while busy is ignored.

## Timing
- Reset values:
  - `state`=IDLE, `beats_left`=0, `first_q`=0, `done`=0.
  - `op_ready`=1, `busy`=0.
  - `in_ready`, `wb_valid`, `wb_last`, `enable_acc` all 0; all mux outputs 0.
- Accept to RUN takes 1 cycle. The first beat can be consumed in the first RUN cycle.
- Elementwise ops have zero-cycle latency, beat to writeback. `in_ready` depends combinationally on `wb_ready`, and `wb_valid` on `in_valid`.
- Stall behaviour:
  - `wb_ready=0` stalls elementwise ops: no `hs`, `beats_left` holds.
  - In MAC RUN, `in_valid=0` leaves `enable_acc=0`, so the accumulator holds.
- MAC latency: FINAL is entered the cycle after the last beat. Writeback stays high until `wb_ready`.
- `done` is registered and rises the cycle after the completing handshake (or after a length-0 accept).
- The next op can be accepted in the same cycle `done` is high.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. The in-flight op is dropped; the PE accumulator is reset by the shared `n_reset`.

## Structure
- `pe_ctrl_pkg` contains:
  - the `op_e` enum;
  - `localparam` encodings for every PE mux select (ADD_A_IN, ADD_A_MUL, ADD_A_TREE, ADD_B_IN, ADD_B_CACC, SAT8_CACC, SAT8_MUL, SAT8_ADD, RES_MUL, RES_ADD12, RES_SAT8, RES_RELU);
  - the `state_e` enum.
- Single module, no sub-module: the FSM and counter are combined with a combinational control decoder.

## Test plan
- ADD, len 3, `wb_ready=1`, beats (100,50), (-3,5), (0,0):
  - three writebacks, `wb_last` on the third;
  - controls add_a=0, add_b=0, sat8=2, res=2, comb=1;
  - with a PE attached, `r` = 127, 2, 0;
  - `done` pulses one cycle after the third beat.
- MAC, len 4, four beats (32,16):
  - beat 0: res=0, enable_acc=1;
  - beats 1-3: add_a=1, add_b=1, c_acc=1, res=1;
  - FINAL: c_acc=1, sat8=0, res=2, comb=1, enable_acc=0, `wb_valid=1`;
  - with a PE attached, acc=128 and `r`=127.
- Backpressure: ADD len 2 with `wb_ready` low for 3 cycles → `in_ready=0`, `beats_left` stays 2, then the op completes normally.
- MAC with `op_relu=1` and FINAL held for 4 cycles with `wb_ready=0` → FINAL controls and `wb_valid` stay stable, `mux_relu=1`, `mux_res=3`; with a PE, an accumulator of -20 gives `r`=0.
- `op_len=0` → `state` stays IDLE, `in_ready` and `wb_valid` never rise, `done` pulses the next cycle.
- Reset after 2 MAC beats → all outputs return to their reset values immediately, `op_ready=1`; a new ADD len 1 is accepted afterwards and completes.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg
//   Shared types and PE mux-select encodings for the processing_element
//   issue controller (pe_sequencer).
//   - op_e    : vector operation codes carried on op_code.
//   - state_e : sequencer FSM states (also exported on the debug port).
//   - ADD_A_*, ADD_B_*, SAT8_*, RES_* : select values for the PE muxes.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_MUL  = 2'd1,
    OP_MAC  = 2'd2,
    OP_RELU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  // Adder A-input select
  localparam logic [1:0] ADD_A_IN   = 2'd0;
  localparam logic [1:0] ADD_A_MUL  = 2'd1;
  localparam logic [1:0] ADD_A_TREE = 2'd2;

  // Adder B-input select
  localparam logic [1:0] ADD_B_IN   = 2'd0;
  localparam logic [1:0] ADD_B_CACC = 2'd1;

  // int8 saturator source select
  localparam logic [1:0] SAT8_CACC  = 2'd0;
  localparam logic [1:0] SAT8_MUL   = 2'd1;
  localparam logic [1:0] SAT8_ADD   = 2'd2;

  // Result select
  localparam logic [1:0] RES_MUL    = 2'd0;
  localparam logic [1:0] RES_ADD12  = 2'd1;
  localparam logic [1:0] RES_SAT8   = 2'd2;
  localparam logic [1:0] RES_RELU   = 2'd3;

  // Result select for a saturated int8 value, optionally passed through ReLU.
  function automatic logic [1:0] res_sel(input logic relu);
    return relu ? RES_RELU : RES_SAT8;
  endfunction

endpackage

// File: rtl/pe_sequencer.sv
// pe_sequencer
//   Issue-side controller for one processing_element lane. Accepts a vector
//   operation, consumes operand beats, drives every PE control pin cycle by
//   cycle and hands PE results to writeback.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
//   clk edge where valid and ready are both high. valid never waits on ready;
//   in_ready depends combinationally on wb_ready and wb_valid on in_valid for
//   elementwise ops (zero-latency pass-through of the PE result).
//
// Ports
//   clk, n_reset (async, active-low)
//   op_valid/op_ready, op_code, op_len, op_relu : operation issue
//   in_valid/in_ready                           : operand beat stream
//   wb_valid/wb_ready, wb_last                  : result writeback
//   mux_*, enable_acc                           : PE control pins
//   busy, done                                  : status (done = 1-cycle pulse)
//   dbg_state_o, dbg_beats_left_o               : FSM state / beat counter
module pe_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [LEN_W-1:0] op_len,
  input  logic             op_relu,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic             wb_last,
  output logic [1:0]       mux_add_a,
  output logic [1:0]       mux_add_b,
  output logic             mux_c_acc,
  output logic [1:0]       mux_sat8,
  output logic             mux_relu,
  output logic [1:0]       mux_res,
  output logic             mux_comb,
  output logic             enable_acc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o,
  output logic [LEN_W-1:0] dbg_beats_left_o
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] beats_left_q, beats_left_d;
  op_e              op_q, op_d;
  logic             relu_q, relu_d;
  logic             first_q, first_d;
  logic             done_q, done_d;
  logic             hs;
  logic             last_beat;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      op_q         <= OP_ADD;
      relu_q       <= 1'b0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      op_q         <= op_d;
      relu_q       <= relu_d;
      first_q      <= first_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    op_d         = op_q;
    relu_d       = relu_q;
    first_d      = first_q;
    done_d       = 1'b0;
    op_ready     = 1'b0;
    in_ready     = 1'b0;
    wb_valid     = 1'b0;
    wb_last      = 1'b0;
    mux_add_a    = ADD_A_IN;
    mux_add_b    = ADD_B_IN;
    mux_c_acc    = 1'b0;
    mux_sat8     = SAT8_CACC;
    mux_relu     = 1'b0;
    mux_res      = RES_MUL;
    mux_comb     = 1'b0;
    enable_acc   = 1'b0;
    hs           = 1'b0;
    last_beat    = (beats_left_q == LEN_W'(1));

    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (op_len != '0) begin
            state_d      = ST_RUN;
            op_d         = op_e'(op_code);
            relu_d       = op_relu;
            beats_left_d = op_len;
            first_d      = 1'b1;
          end else begin
            // Empty operation: nothing to fetch or write back, just report.
            done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (op_q == OP_MAC) begin
          // Accumulate phase: no writeback, so beats are never back-pressured.
          in_ready   = 1'b1;
          hs         = in_valid;
          enable_acc = hs;
          if (first_q) begin
            mux_res = RES_MUL;          // load truncated product
          end else begin
            mux_add_a = ADD_A_MUL;
            mux_add_b = ADD_B_CACC;
            mux_c_acc = 1'b1;
            mux_res   = RES_ADD12;      // saturated 12-bit accumulate
          end
        end else begin
          // Elementwise: a beat is only taken when writeback can take its result.
          in_ready = wb_ready;
          wb_valid = in_valid;
          wb_last  = last_beat;
          mux_comb = 1'b1;
          hs       = in_valid & wb_ready;
          case (op_q)
            OP_ADD: begin
              mux_add_a = ADD_A_IN;
              mux_add_b = ADD_B_IN;
              mux_sat8  = SAT8_ADD;
              mux_relu  = relu_q;
              mux_res   = res_sel(relu_q);
            end
            OP_MUL: begin
              mux_sat8 = SAT8_MUL;
              mux_relu = relu_q;
              mux_res  = res_sel(relu_q);
            end
            default: begin
              mux_res = RES_RELU;
            end
          endcase
        end

        if (hs) begin
          beats_left_d = beats_left_q - LEN_W'(1);
          first_d      = 1'b0;
          if (last_beat) begin
            if (op_q == OP_MAC) begin
              state_d = ST_FINAL;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      ST_FINAL: begin
        // Present the accumulator, saturated to int8, until writeback takes it.
        wb_valid  = 1'b1;
        wb_last   = 1'b1;
        mux_c_acc = 1'b1;
        mux_sat8  = SAT8_CACC;
        mux_comb  = 1'b1;
        mux_relu  = relu_q;
        mux_res   = res_sel(relu_q);
        if (wb_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy             = (state_q != ST_IDLE);
  assign done             = done_q;
  assign dbg_state_o      = state_q;
  assign dbg_beats_left_o = beats_left_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer
//   Bench for pe_sequencer: reset checks, a table of cycle-by-cycle vectors,
//   a hand-written mid-operation reset sequence, and a randomized run checked
//   against a transaction-level reference model (expected beat/writeback
//   events and done pulses derived from the operation definitions).
module tb_pe_sequencer;
  import pe_ctrl_pkg::*;

  localparam int LEN_W = 8;
  localparam int NOPS  = 80;
  localparam logic [1:0] C_ADD = 2'd0, C_MUL = 2'd1, C_MAC = 2'd2, C_RELU = 2'd3;

  logic             clk = 1'b0;
  logic             n_reset = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [1:0]       op_code = 2'd0;
  logic [LEN_W-1:0] op_len = '0;
  logic             op_relu = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic             wb_last;
  logic [1:0]       mux_add_a, mux_add_b, mux_sat8, mux_res;
  logic             mux_c_acc, mux_relu, mux_comb, enable_acc;
  logic             busy, done;
  logic [1:0]       dbg_state_o;
  logic [LEN_W-1:0] dbg_beats_left_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pe_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .n_reset(n_reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_len(op_len), .op_relu(op_relu),
    .in_valid(in_valid), .in_ready(in_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_last(wb_last),
    .mux_add_a(mux_add_a), .mux_add_b(mux_add_b), .mux_c_acc(mux_c_acc),
    .mux_sat8(mux_sat8), .mux_relu(mux_relu), .mux_res(mux_res),
    .mux_comb(mux_comb), .enable_acc(enable_acc),
    .busy(busy), .done(done),
    .dbg_state_o(dbg_state_o), .dbg_beats_left_o(dbg_beats_left_o)
  );

  logic [11:0] ctl_obs;
  logic [5:0]  flags_obs;
  assign ctl_obs   = {mux_add_a, mux_add_b, mux_c_acc, mux_sat8, mux_relu,
                      mux_res, mux_comb, enable_acc};
  assign flags_obs = {op_ready, busy, in_ready, wb_valid, wb_last, done};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- expected control words ----------------
  function automatic logic [11:0] mk_ctl(input logic [1:0] aa, input logic [1:0] ab,
                                         input logic ca, input logic [1:0] s8,
                                         input logic rl, input logic [1:0] rs,
                                         input logic cb, input logic en);
    return {aa, ab, ca, s8, rl, rs, cb, en};
  endfunction
  function automatic logic [11:0] ctl_add(input logic r);
    return mk_ctl(2'd0, 2'd0, 1'b0, 2'd2, r, r ? 2'd3 : 2'd2, 1'b1, 1'b0);
  endfunction
  function automatic logic [11:0] ctl_mul(input logic r);
    return mk_ctl(2'd0, 2'd0, 1'b0, 2'd1, r, r ? 2'd3 : 2'd2, 1'b1, 1'b0);
  endfunction
  function automatic logic [11:0] ctl_relu();
    return mk_ctl(2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1, 1'b0);
  endfunction
  function automatic logic [11:0] ctl_mac_first();
    return mk_ctl(2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
  endfunction
  function automatic logic [11:0] ctl_mac_acc(input logic en);
    return mk_ctl(2'd1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, en);
  endfunction
  function automatic logic [11:0] ctl_mac_final(input logic r);
    return mk_ctl(2'd0, 2'd0, 1'b1, 2'd0, r, r ? 2'd3 : 2'd2, 1'b1, 1'b0);
  endfunction
  function automatic logic [11:0] ctl_elem(input logic [1:0] code, input logic r);
    case (code)
      C_ADD:   return ctl_add(r);
      C_MUL:   return ctl_mul(r);
      default: return ctl_relu();
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic             ov;
    logic [1:0]       code;
    logic [LEN_W-1:0] len;
    logic             relu;
    logic             iv;
    logic             wr;
    logic [5:0]       flags;  // {op_ready, busy, in_ready, wb_valid, wb_last, done}
    logic [1:0]       st;
    logic [LEN_W-1:0] bl;
    logic [11:0]      ctl;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic ov, input logic [1:0] code, input int len,
                         input logic relu, input logic iv, input logic wr,
                         input logic [5:0] flags, input logic [1:0] st,
                         input int bl, input logic [11:0] ctl);
    vec_t v;
    v.ov = ov; v.code = code; v.len = LEN_W'(len); v.relu = relu;
    v.iv = iv; v.wr = wr; v.flags = flags; v.st = st; v.bl = LEN_W'(bl); v.ctl = ctl;
    vq.push_back(v);
  endtask

  // ---------------- reference model (random phase) ----------------
  // Record: {completes_op, beat_taken, wb_taken, wb_last, ctl[11:0]}
  logic [15:0] exp_q[$];

  task automatic push_op(input logic [1:0] code, input int len, input logic r);
    if (len == 0) return;
    if (code != C_MAC) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({(i == len - 1), 1'b1, 1'b1, (i == len - 1), ctl_elem(code, r)});
    end else begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0,
                         (i == 0) ? ctl_mac_first() : ctl_mac_acc(1'b1)});
      exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b1, ctl_mac_final(r)});
    end
  endtask

  initial begin
    // ---- reset ----
    #2;
    check("reset_in", {flags_obs, dbg_state_o, dbg_beats_left_o, ctl_obs},
          {6'b100000, 2'd0, 8'd0, 12'd0});
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1; wb_ready = 1'b1;
    @(negedge clk);
    check("reset_out", {flags_obs, dbg_state_o, dbg_beats_left_o, ctl_obs},
          {6'b100000, 2'd0, 8'd0, 12'd0});

    // ---- table ----
    // ADD len 3, full throughput; next op accepted on the done cycle
    add_vec(1, C_ADD, 3, 0, 0, 1, 6'b100000, 2'd0, 0, 12'd0);
    add_vec(0, C_ADD, 0, 0, 1, 1, 6'b011100, 2'd1, 3, ctl_add(0));
    add_vec(0, C_ADD, 0, 0, 1, 1, 6'b011100, 2'd1, 2, ctl_add(0));
    add_vec(0, C_ADD, 0, 0, 1, 1, 6'b011110, 2'd1, 1, ctl_add(0));
    add_vec(1, C_MAC, 4, 0, 0, 1, 6'b100001, 2'd0, 0, 12'd0);
    // MAC len 4 with one input bubble, FINAL held one cycle
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b011000, 2'd1, 4, ctl_mac_first());
    add_vec(0, C_ADD, 0, 0, 0, 0, 6'b011000, 2'd1, 3, ctl_mac_acc(0));
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b011000, 2'd1, 3, ctl_mac_acc(1));
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b011000, 2'd1, 2, ctl_mac_acc(1));
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b011000, 2'd1, 1, ctl_mac_acc(1));
    add_vec(0, C_ADD, 0, 0, 0, 0, 6'b010110, 2'd2, 0, ctl_mac_final(0));
    add_vec(0, C_ADD, 0, 0, 0, 1, 6'b010110, 2'd2, 0, ctl_mac_final(0));
    add_vec(0, C_ADD, 0, 0, 0, 1, 6'b100001, 2'd0, 0, 12'd0);
    // ADD len 2 with writeback back-pressure for 3 cycles
    add_vec(1, C_ADD, 2, 0, 0, 1, 6'b100000, 2'd0, 0, 12'd0);
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b010100, 2'd1, 2, ctl_add(0));
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b010100, 2'd1, 2, ctl_add(0));
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b010100, 2'd1, 2, ctl_add(0));
    add_vec(0, C_ADD, 0, 0, 1, 1, 6'b011100, 2'd1, 2, ctl_add(0));
    add_vec(0, C_ADD, 0, 0, 1, 1, 6'b011110, 2'd1, 1, ctl_add(0));
    // MUL with ReLU, then RELU op (op_relu ignored)
    add_vec(1, C_MUL, 1, 1, 0, 1, 6'b100001, 2'd0, 0, 12'd0);
    add_vec(0, C_ADD, 0, 0, 1, 1, 6'b011110, 2'd1, 1, ctl_mul(1));
    add_vec(1, C_RELU, 1, 0, 0, 1, 6'b100001, 2'd0, 0, 12'd0);
    add_vec(0, C_ADD, 0, 0, 1, 1, 6'b011110, 2'd1, 1, ctl_relu());
    // MAC len 1 with ReLU, FINAL stalled 4 cycles with stray op_valid/in_valid
    add_vec(1, C_MAC, 1, 1, 0, 1, 6'b100001, 2'd0, 0, 12'd0);
    add_vec(0, C_ADD, 0, 0, 1, 0, 6'b011000, 2'd1, 1, ctl_mac_first());
    for (int i = 0; i < 4; i++)
      add_vec(1, C_ADD, 5, 0, 1, 0, 6'b010110, 2'd2, 0, ctl_mac_final(1));
    add_vec(0, C_ADD, 0, 0, 0, 1, 6'b010110, 2'd2, 0, ctl_mac_final(1));
    // length-0 op accepted on the done cycle
    add_vec(1, C_ADD, 0, 0, 0, 1, 6'b100001, 2'd0, 0, 12'd0);
    add_vec(0, C_ADD, 0, 0, 0, 1, 6'b100001, 2'd0, 0, 12'd0);
    add_vec(0, C_ADD, 0, 0, 0, 1, 6'b100000, 2'd0, 0, 12'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      op_valid = vq[i].ov; op_code = vq[i].code; op_len = vq[i].len;
      op_relu  = vq[i].relu; in_valid = vq[i].iv; wb_ready = vq[i].wr;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {flags_obs, dbg_state_o, dbg_beats_left_o, ctl_obs},
            {vq[i].flags, vq[i].st, vq[i].bl, vq[i].ctl});
    end

    // ---- reset in the middle of a MAC ----
    @(posedge clk);
    #1 op_valid = 1'b1; op_code = C_MAC; op_len = 8'd4; op_relu = 1'b0;
    in_valid = 1'b0; wb_ready = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset", {dbg_state_o, dbg_beats_left_o}, {2'd1, 8'd2});
    #2 n_reset = 1'b0;
    #1;
    check("reset_mid", {flags_obs, dbg_state_o, dbg_beats_left_o, ctl_obs},
          {6'b100000, 2'd0, 8'd0, 12'd0});
    @(posedge clk);
    #1 n_reset = 1'b1; op_valid = 1'b1; op_code = C_ADD; op_len = 8'd1;
    in_valid = 1'b1; wb_ready = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    check("post_reset_beat", {flags_obs, dbg_state_o, dbg_beats_left_o, ctl_obs},
          {6'b011110, 2'd1, 8'd1, ctl_add(0)});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("post_reset_done", {flags_obs, dbg_state_o}, {6'b100001, 2'd0});

    // ---- randomized run against the reference model ----
    begin
      int          issued = 0;
      int          cyc = 0;
      int          l;
      logic        done_due = 1'b0;
      logic        finished = 1'b0;
      logic        hs_o, wbhs_o;
      logic [15:0] e;
      while (!finished && cyc < 20000) begin
        @(posedge clk);
        #1;
        cyc++;
        if (!busy) begin
          if (issued < NOPS && $urandom_range(0, 3) != 0) begin
            l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            op_valid = 1'b1;
            op_code  = 2'($urandom_range(0, 3));
            op_len   = LEN_W'(l);
            op_relu  = 1'($urandom_range(0, 1));
            push_op(op_code, l, op_relu);
            issued++;
          end else begin
            op_valid = 1'b0;
          end
        end else begin
          op_valid = 1'($urandom_range(0, 1));
          op_code  = 2'($urandom_range(0, 3));
          op_len   = LEN_W'($urandom_range(0, 6));
          op_relu  = 1'($urandom_range(0, 1));
        end
        in_valid = ($urandom_range(0, 9) < 7);
        wb_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);

        check("rnd_done", done, done_due);
        done_due = 1'b0;
        hs_o   = in_valid & in_ready;
        wbhs_o = wb_valid & wb_ready;
        if (hs_o || wbhs_o) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rnd_extra_event actual=%0h required=none at %0t",
                     {hs_o, wbhs_o, wb_last, ctl_obs}, $time);
          end else begin
            e = exp_q.pop_front();
            check("rnd_event", {hs_o, wbhs_o, wb_last, ctl_obs}, e[14:0]);
            if (e[15]) done_due = 1'b1;
          end
        end else if (busy) begin
          check("rnd_acc_hold", enable_acc, 1'b0);
        end
        if (!busy)
          check("rnd_idle_quiet", {in_ready, wb_valid, wb_last, ctl_obs}, 15'd0);
        if (op_valid && op_ready && op_len == '0) done_due = 1'b1;

        finished = (issued == NOPS) && !busy && (exp_q.size() == 0) && !done_due &&
                   !(op_valid && op_ready);
      end
      if (!finished) begin
        total++;
        bad++;
        $display("FAIL rnd_timeout actual=%0d_pending required=0", exp_q.size());
      end
      op_valid = 1'b0;
      in_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
